// File: rtl/dac_feeder_pkg.sv
// dac_feeder_pkg: shared FSM state encoding and default sample width / FIFO depth.
package dac_feeder_pkg;
    localparam int DEF_BITDEPTH = 12;
    localparam int DEF_DEPTH = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN = 2'd2;
endpackage

// File: rtl/dac_feeder_if.sv
// dac_feeder_if: producer write channel (wr_valid/wr_data in, wr_ready back); master = producer, slave = feeder.
interface dac_feeder_if import dac_feeder_pkg::*; #(parameter int BITDEPTH = DEF_BITDEPTH);
    logic                wr_valid;
    logic [BITDEPTH-1:0] wr_data;
    logic                wr_ready;
    modport master (output wr_valid, wr_data, input wr_ready);
    modport slave (input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/dac_feeder_pcm_fifo.sv
// pcm_fifo: synchronous sample FIFO; ports clk/rst, flush (clear, wins over push/pop), wr_en/wr_data push, rd_en pop, rd_data head, level/full/empty status.
module pcm_fifo import dac_feeder_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int BITDEPTH = DEF_BITDEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [BITDEPTH-1:0]      wr_data,
    input  logic                     rd_en,
    output logic [BITDEPTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    logic [BITDEPTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_go, rd_go;
    assign full = level == FULL_LVL;
    assign empty = level == '0;
    assign rd_data = mem[rp];
    // full blocks a push even when a pop happens in the same cycle
    assign wr_go = wr_en && !full && !flush;
    assign rd_go = rd_en && !empty && !flush;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            wp <= wp + AW'(wr_go);
            rp <= rp + AW'(rd_go);
            level <= level + (AW+1)'(wr_go) - (AW+1)'(rd_go);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_go) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/dac_feeder.sv
// dac_feeder: paced PCM playback from a FIFO; ports enable/flush/divider control, wr (producer channel), low_thresh/level/irq_low refill, underrun/clr_underrun, pcm/sample_strobe to the DAC.
module dac_feeder import dac_feeder_pkg::*; #(
    parameter int BITDEPTH = DEF_BITDEPTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [15:0]            divider,
    dac_feeder_if.slave            wr,
    input  logic [$clog2(DEPTH):0] low_thresh,
    output logic [$clog2(DEPTH):0] level,
    output logic                   irq_low,
    output logic                   underrun,
    input  logic                   clr_underrun,
    output logic [BITDEPTH-1:0]    pcm,
    output logic                   sample_strobe
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    logic [1:0] state;
    logic [15:0] presc;
    logic [BITDEPTH-1:0] head;
    logic full, empty, tick, pop;
    assign tick = state == ST_RUN && presc == '0;
    assign pop = tick && !empty && !flush;
    assign wr.wr_ready = !full;
    pcm_fifo #(.DEPTH(DEPTH), .BITDEPTH(BITDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr.wr_valid),
        .wr_data (wr.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            presc <= '0;
            pcm <= '0;
            sample_strobe <= 1'b0;
            underrun <= 1'b0;
            irq_low <= 1'b0;
        end else begin
            state <= !enable ? ST_IDLE :
                     state == ST_IDLE ? ST_PRIME :
                     (state == ST_PRIME && level >= PRIME_LVL) ? ST_RUN : state;
            // divider is sampled only on reload, so a change lands after the current period
            presc <= (state != ST_RUN || presc == '0) ? divider : presc - 16'd1;
            sample_strobe <= pop;
            if (pop) pcm <= head;
            // an empty-FIFO tick sets the flag even when software clears it in the same cycle
            underrun <= (tick && empty) || (underrun && !clr_underrun);
            irq_low <= state != ST_IDLE && level <= low_thresh;
        end
    end
endmodule

// File: tb/tb_dac_feeder.sv
// tb_dac_feeder: directed scenarios for dac_feeder checked against a queue-based playback model every cycle.
module tb_dac_feeder;
    localparam int DEPTH = 16;
    localparam int PRIME = 8;
    typedef enum int {M_IDLE, M_PRIME, M_RUN} mstate_t;
    logic clk = 1'b0;
    logic rst, enable, flush, clr_underrun;
    logic [15:0] divider;
    logic [4:0] low_thresh, level;
    logic irq_low, underrun, sample_strobe;
    logic [11:0] pcm;
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [11:0] m_q[$];
    mstate_t m_state = M_IDLE;
    int m_cnt = 0;
    logic [11:0] m_pcm = '0;
    logic m_stb = 1'b0;
    logic m_und = 1'b0;
    logic m_irq = 1'b0;
    dac_feeder_if #(.BITDEPTH(12)) wr_if ();
    dac_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .divider       (divider),
        .wr            (wr_if),
        .low_thresh    (low_thresh),
        .level         (level),
        .irq_low       (irq_low),
        .underrun      (underrun),
        .clr_underrun  (clr_underrun),
        .pcm           (pcm),
        .sample_strobe (sample_strobe)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    // Playback rules: a sample leaves the queue once per (divider+1) cycles while playing.
    task automatic model_step();
        bit tick, empty, pop, acc;
        int lvl;
        if (rst) begin
            m_q.delete();
            m_state = M_IDLE;
            m_cnt = 0;
            m_pcm = '0;
            m_stb = 1'b0;
            m_und = 1'b0;
            m_irq = 1'b0;
        end else begin
            lvl = m_q.size();
            empty = lvl == 0;
            tick = m_state == M_RUN && m_cnt == 0;
            pop = tick && !empty && !flush;
            acc = wr_if.wr_valid && lvl != DEPTH && !flush;
            m_irq = m_state != M_IDLE && lvl <= int'(low_thresh);
            if (tick && empty) m_und = 1'b1;
            else if (clr_underrun) m_und = 1'b0;
            m_stb = pop;
            if (pop) m_pcm = m_q.pop_front();
            if (flush) m_q.delete();
            else if (acc) m_q.push_back(wr_if.wr_data);
            if (m_state != M_RUN || m_cnt == 0) m_cnt = int'(divider);
            else m_cnt = m_cnt - 1;
            if (!enable) m_state = M_IDLE;
            else if (m_state == M_IDLE) m_state = M_PRIME;
            else if (m_state == M_PRIME && lvl >= PRIME) m_state = M_RUN;
        end
    endtask
    initial forever @(posedge clk) cyc++;
    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("pcm", 32'(pcm), 32'(m_pcm));
            chk("sample_strobe", 32'(sample_strobe), 32'(m_stb));
            chk("level", 32'(level), m_q.size());
            chk("wr_ready", 32'(wr_if.wr_ready), 32'(m_q.size() != DEPTH));
            chk("underrun", 32'(underrun), 32'(m_und));
            chk("irq_low", 32'(irq_low), 32'(m_irq));
        end
    end
    task automatic wait_strobe(output int t);
        t = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sample_strobe === 1'b1) begin
                t = cyc;
                break;
            end
        end
        n_vec++;
        if (t < 0) begin
            n_bad++;
            $display("FAIL strobe_wait at cycle %0d: got none expected a strobe within 64 cycles", cyc);
        end
    endtask
    task automatic wait_level(input int v);
        bit hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (int'(level) == v) begin
                hit = 1;
                break;
            end
        end
        n_vec++;
        if (!hit) begin
            n_bad++;
            $display("FAIL level_wait at cycle %0d: got %0d expected %0d", cyc, level, v);
        end
    endtask
    task automatic write_n(input logic [11:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data = base + 12'(i);
            @(negedge clk);
        end
        wr_if.wr_valid = 1'b0;
    endtask
    task automatic clear_flag();
        @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("underrun_cleared", 32'(underrun), 0);
    endtask
    initial begin
        int t, tp;
        rst = 1'b1;
        enable = 1'b0;
        flush = 1'b0;
        clr_underrun = 1'b0;
        divider = 16'd3;
        low_thresh = 5'd4;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_pcm", 32'(pcm), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_strobe", 32'(sample_strobe), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_irq", 32'(irq_low), 0);
        chk("rst_wr_ready", 32'(wr_if.wr_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        // steady playback, one sample every 4 clocks
        enable = 1'b1;
        write_n(12'h100, 8);
        wait_strobe(t);
        chk("play_first", 32'(pcm), 32'h100);
        for (int i = 1; i < 8; i++) begin
            tp = t;
            wait_strobe(t);
            chk("play_gap", t - tp, 4);
            chk("play_pcm", 32'(pcm), 32'h100 + i);
        end
        repeat (4) @(negedge clk);
        chk("under_set", 32'(underrun), 1);
        chk("under_hold_pcm", 32'(pcm), 32'h107);
        chk("under_no_strobe", 32'(sample_strobe), 0);
        // two-sample refill, then starve again
        clr_underrun = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 12'h200;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("under_clr_run", 32'(underrun), 0);
        wr_if.wr_data = 12'h201;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        wait_strobe(t);
        chk("two_a", 32'(pcm), 32'h200);
        tp = t;
        wait_strobe(t);
        chk("two_b", 32'(pcm), 32'h201);
        chk("two_gap", t - tp, 4);
        repeat (4) @(negedge clk);
        chk("two_under", 32'(underrun), 1);
        chk("two_hold", 32'(pcm), 32'h201);
        chk("two_no_strobe", 32'(sample_strobe), 0);
        enable = 1'b0;
        clear_flag();
        // fill to full while idle
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        write_n(12'h300, 16);
        chk("full_level", 32'(level), 16);
        chk("full_ready", 32'(wr_if.wr_ready), 0);
        write_n(12'h3FF, 1);
        chk("full_drop", 32'(level), 16);
        enable = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 12'h3EE;
        repeat (6) @(negedge clk);
        wr_if.wr_valid = 1'b0;
        chk("full_tick_level", 32'(level), 15);
        chk("full_tick_strobe", 32'(sample_strobe), 1);
        chk("full_tick_pcm", 32'(pcm), 32'h300);
        // flush colliding with a write and a tick
        wait_level(5);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 12'h555;
        @(negedge clk);
        flush = 1'b0;
        wr_if.wr_valid = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_pcm", 32'(pcm), 32'h30A);
        chk("flush_strobe", 32'(sample_strobe), 0);
        chk("flush_underrun", 32'(underrun), 0);
        enable = 1'b0;
        clear_flag();
        // fast drain, refill threshold, divider change mid-period
        divider = 16'd0;
        write_n(12'h400, 8);
        enable = 1'b1;
        wait_level(4);
        chk("irq_lag", 32'(irq_low), 0);
        divider = 16'd9;
        wait_strobe(t);
        chk("irq_rise", 32'(irq_low), 1);
        chk("drain_level", 32'(level), 3);
        chk("drain_pcm", 32'(pcm), 32'h404);
        divider = 16'd3;
        tp = t;
        wait_strobe(t);
        chk("div9_gap", t - tp, 10);
        chk("div9_pcm", 32'(pcm), 32'h405);
        tp = t;
        wait_strobe(t);
        chk("div3_gap", t - tp, 4);
        chk("div3_pcm", 32'(pcm), 32'h406);
        // asynchronous reset right after a strobe, between edges
        #1 rst = 1'b1;
        #1;
        chk("arst_pcm", 32'(pcm), 0);
        chk("arst_strobe", 32'(sample_strobe), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_irq", 32'(irq_low), 0);
        chk("arst_underrun", 32'(underrun), 0);
        chk("arst_ready", 32'(wr_if.wr_ready), 1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/dac_feeder.md
DAC_FEEDER -- requirements
Module: dac_feeder

Interface
REQ-001 Parameter BITDEPTH, default 12: PCM sample width.
REQ-002 Parameter DEPTH, default 16: FIFO entries; power of two, at least 4.
REQ-003 Parameter PRIME_LEVEL, default 8: FIFO level that starts playback; 1 to DEPTH.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  playback enable.
REQ-007 flush  in  1  one-cycle FIFO clear.
REQ-008 divider  in  16  sample period minus one, in clk cycles.
REQ-009 wr_valid  in  1  producer sample valid.
REQ-010 wr_data  in  BITDEPTH  producer sample.
REQ-011 wr_ready  out  1  FIFO can accept a sample.
REQ-012 low_thresh  in  log2(DEPTH)+1  refill threshold.
REQ-013 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 irq_low  out  1  refill request.
REQ-015 underrun  out  1  sticky underrun flag.
REQ-016 clr_underrun  in  1  clears underrun.
REQ-017 pcm  out  BITDEPTH  sample to the DAC pcm input.
REQ-018 sample_strobe  out  1  one-cycle pulse, asserted in the first cycle each new pcm is visible.

Function
REQ-019 The FSM SHALL have three states: IDLE, PRIME, RUN.
REQ-020 IDLE->PRIME when enable=1; PRIME->RUN when level>=PRIME_LEVEL; any state->IDLE when enable=0.
REQ-021 In IDLE and PRIME the prescaler SHALL hold the value divider and produce no ticks.
REQ-022 In RUN the prescaler SHALL count down to 0, produce a one-cycle tick at 0, then reload divider.
REQ-023 A changed divider SHALL take effect at the next reload; divider=0 SHALL tick every cycle.
REQ-024 On a tick with the FIFO non-empty, the head SHALL be popped, loaded into pcm, and sample_strobe asserted the following cycle; latency from tick to pcm is 1 clk.
REQ-025 On a tick with the FIFO empty, pcm SHALL hold its last value, no strobe SHALL be issued, underrun SHALL be set, and the FSM SHALL stay in RUN.
REQ-026 A write SHALL be accepted when wr_valid and wr_ready are both 1 in the same cycle.
REQ-027 wr_ready SHALL equal "not full"; when the FIFO is full it stays 0 even if a pop occurs in the same cycle.
REQ-028 A write and a pop in the same cycle SHALL leave level unchanged.
REQ-029 A write to an empty FIFO SHALL NOT bypass to pcm; a tick in that same cycle is an underrun.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; level SHALL span 0 to DEPTH inclusive.
REQ-031 flush SHALL empty the FIFO and has priority over any write or pop in the same cycle; the FSM state and pcm SHALL be unchanged.
REQ-032 irq_low SHALL be registered and equal (state!=IDLE) AND (level<=low_thresh).
REQ-033 When underrun is set and clr_underrun is asserted in the same cycle, set SHALL win.
REQ-034 FIFO contents SHALL survive enable=0; pcm SHALL hold its value in IDLE.

Reset
REQ-035 rst SHALL force state=IDLE, an empty FIFO, level=0, pcm=0, sample_strobe=0, underrun=0, irq_low=0, and prescaler=0.
REQ-036 Reset asserted mid-playback SHALL take effect immediately and asynchronously, with no further strobe.

Structure
REQ-037 A shared package dac_feeder_pkg SHALL hold the FSM state encoding and the default BITDEPTH and DEPTH constants.
REQ-038 Storage SHALL be one synchronous FIFO sub-module, pcm_fifo, with DEPTH/BITDEPTH parameters and flush, level, and full/empty outputs; the FSM, prescaler, and flags SHALL reside in dac_feeder.

Verification
REQ-039 Scenario: enable=1, divider=3, write 8 samples 0x100..0x107 -> RUN entered when level reaches 8; pcm takes 0x100, 0x101, ... with one strobe every 4 clk.
REQ-040 Scenario: RUN with divider=3 and only 2 samples -> after both pop, the next tick sets underrun, pcm holds the last sample, and there is no strobe; clr_underrun then clears underrun.
REQ-041 Scenario: fill 16 samples with enable=0 -> wr_ready=0 and level=16; a 17th write is not accepted; enable=1 -> RUN immediately; write on the tick cycle when full -> not accepted.
REQ-042 Scenario: level=5, flush with simultaneous write and tick -> level=0, the write is dropped, pcm is unchanged, and no strobe is issued.
REQ-043 Scenario: low_thresh=4, drain from 8 at divider=0 -> irq_low rises one cycle after level reaches 4; divider changed 0->9 mid-count applies after the next tick.
REQ-044 Scenario: assert rst asynchronously between clk edges during RUN -> all outputs reach their reset values before the next edge.
